// File: rtl/mul_div_if.sv
// Handshake and HI/LO bus of the multiply/divide unit.
// The master drives operations; the slave exposes busy/done/HI/LO.
interface mul_div_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, src_a, src_b,
    output hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b,
    input  hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Fixed 33-cycle latency: 32 radix-2 steps plus one sign-fix cycle.
module mul_div_unit (
  input  logic     clk,
  input  logic     rst,
  mul_div_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t      state_q;
  logic [1:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] opnd_q;
  logic        sa_q;
  logic        sb_q;
  logic [5:0]  cnt_q;
  logic [63:0] acc_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic [63:0] acc_d;
  logic [31:0] hi_d;
  logic [31:0] lo_d;
  logic [32:0] sum;
  logic [32:0] sh;
  logic [32:0] diff;
  logic        sgn_a;
  logic        sgn_b;
  logic        neg_q;
  logic        neg_r;

  assign sgn_a = ~bus.op[0] & bus.src_a[31];
  assign sgn_b = ~bus.op[0] & bus.src_b[31];

  // One radix-2 step: shift-add multiply or restoring divide.
  always_comb begin
    sum  = {1'b0, acc_q[63:32]} + {1'b0, opnd_q};
    sh   = {acc_q[63:32], acc_q[31]};
    diff = sh - {1'b0, opnd_q};
    if (op_q[1]) begin
      if (diff[32])
        acc_d = {sh[31:0], acc_q[30:0], 1'b0};
      else
        acc_d = {diff[31:0], acc_q[30:0], 1'b1};
    end else begin
      if (acc_q[0])
        acc_d = {sum, acc_q[31:1]};
      else
        acc_d = {1'b0, acc_q[63:1]};
    end
  end

  // Sign correction and divide-by-zero override of the magnitude result.
  always_comb begin
    neg_q = ~op_q[0] & (sa_q ^ sb_q);
    neg_r = ~op_q[0] & sa_q;
    hi_d  = acc_q[63:32];
    lo_d  = acc_q[31:0];
    if (!op_q[1]) begin
      if (neg_q)
        {hi_d, lo_d} = -acc_q;
    end else if (opnd_q == 32'd0) begin
      hi_d = a_q;
      lo_d = 32'hFFFF_FFFF;
    end else begin
      if (neg_q)
        lo_d = -acc_q[31:0];
      if (neg_r)
        hi_d = -acc_q[63:32];
    end
  end

  // Control FSM with registered busy/done and HI/LO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= 2'b00;
      a_q     <= '0;
      opnd_q  <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            op_q    <= bus.op;
            a_q     <= bus.src_a;
            sa_q    <= sgn_a;
            sb_q    <= sgn_b;
            opnd_q  <= sgn_b ? -bus.src_b : bus.src_b;
            acc_q   <= {32'd0,
                        sgn_a ? -bus.src_a : bus.src_a};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            if (bus.hi_we)
              hi_q <= bus.wdata;
            if (bus.lo_we)
              lo_q <= bus.wdata;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31)
            state_q <= FIX;
        end
        FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit.
// Expected HI/LO values are hand-computed constants.
module tb_mul_div_unit;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;
  logic [31:0] cur_hi;
  logic [31:0] cur_lo;

  mul_div_if bus();

  mul_div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  // Launch op at the next edge, optionally inject a
  // start+MTHI at RUN cycle inj, then check result.
  task automatic go(input string tag,
                    input logic [1:0] o,
                    input logic [31:0] a,
                    input logic [31:0] b,
                    input int inj,
                    input logic [31:0] ehi,
                    input logic [31:0] elo);
    int lat;
    bus.op    = o;
    bus.src_a = a;
    bus.src_b = b;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    chk({tag, " busy"}, {31'd0, bus.busy}, 32'd1);
    chk({tag, " hi kept"}, bus.hi, cur_hi);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      if (n == inj) begin
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.src_a = 32'd99;
        bus.src_b = 32'd3;
        bus.hi_we = 1'b1;
        bus.wdata = 32'h1234_5678;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.hi_we = 1'b0;
      if (n == 16)
        chk({tag, " hi mid"}, bus.hi, cur_hi);
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    chk({tag, " latency"}, lat, 32'd33);
    chk({tag, " hi"}, bus.hi, ehi);
    chk({tag, " lo"}, bus.lo, elo);
    chk({tag, " idle"}, {31'd0, bus.busy}, 32'd0);
    cur_hi = ehi;
    cur_lo = elo;
  endtask

  initial begin
    int seen;
    n_chk = 0;
    n_err = 0;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    cur_hi = 32'd0;
    cur_lo = 32'd0;
    #3;
    chk("rst busy", {31'd0, bus.busy}, 32'd0);
    chk("rst done", {31'd0, bus.done}, 32'd0);
    chk("rst hi", bus.hi, 32'd0);
    chk("rst lo", bus.lo, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // MTHI, MTLO and both together
    bus.hi_we = 1'b1;
    bus.wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.hi_we = 1'b0;
    chk("mthi hi", bus.hi, 32'hDEAD_BEEF);
    chk("mthi lo", bus.lo, 32'd0);
    bus.lo_we = 1'b1;
    bus.wdata = 32'h1111_1111;
    @(posedge clk); #1;
    bus.lo_we = 1'b0;
    chk("mtlo lo", bus.lo, 32'h1111_1111);
    chk("mtlo hi", bus.hi, 32'hDEAD_BEEF);
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    chk("mt both hi", bus.hi, 32'hA5A5_A5A5);
    chk("mt both lo", bus.lo, 32'hA5A5_A5A5);
    cur_hi = 32'hA5A5_A5A5;
    cur_lo = 32'hA5A5_A5A5;

    // start with MTHI in the same cycle: write dropped
    bus.hi_we = 1'b1;
    bus.wdata = 32'hCAFE_F00D;
    go("multu start+mthi", 2'b01, 32'd2, 32'd3, 0,
       32'd0, 32'd6);

    // back-to-back directed vectors
    go("multu max", 2'b01, 32'hFFFF_FFFF,
       32'hFFFF_FFFF, 0, 32'hFFFF_FFFE, 32'h0000_0001);
    go("mult -3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, 0,
       32'hFFFF_FFFF, 32'hFFFF_FFEB);
    go("mult minmin", 2'b00, 32'h8000_0000,
       32'h8000_0000, 0, 32'h4000_0000, 32'h0);
    go("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 0,
       32'hFFFF_FFFF, 32'hFFFF_FFFD);
    go("div 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 0,
       32'd1, 32'hFFFF_FFFD);
    go("divu 100/0", 2'b11, 32'd100, 32'd0, 0,
       32'h0000_0064, 32'hFFFF_FFFF);
    go("div -5/0", 2'b10, 32'hFFFF_FFFB, 32'd0, 0,
       32'hFFFF_FFFB, 32'hFFFF_FFFF);
    go("div ovf", 2'b10, 32'h8000_0000,
       32'hFFFF_FFFF, 0, 32'd0, 32'h8000_0000);
    go("divu max/10", 2'b11, 32'hFFFF_FFFF, 32'd10, 0,
       32'd5, 32'h1999_9999);

    // start and MTHI while busy are ignored
    go("multu 5x6 inj", 2'b01, 32'd5, 32'd6, 10,
       32'd0, 32'd30);

    // asynchronous reset in the middle of RUN
    go("multu pre", 2'b01, 32'd9, 32'd9, 0,
       32'd0, 32'd81);
    bus.op    = 2'b01;
    bus.src_a = 32'hFFFF_FFFF;
    bus.src_b = 32'hFFFF_FFFF;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("arst busy", {31'd0, bus.busy}, 32'd0);
    chk("arst done", {31'd0, bus.done}, 32'd0);
    chk("arst hi", bus.hi, 32'd0);
    chk("arst lo", bus.lo, 32'd0);
    cur_hi = 32'd0;
    cur_lo = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy)
        seen++;
    end
    chk("no done after rst", seen, 32'd0);
    chk("post rst hi", bus.hi, 32'd0);
    go("multu after rst", 2'b01, 32'd5, 32'd6, 0,
       32'd0, 32'd30);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
